// File: rtl/jtag_tap_ctrl_pkg.sv
// jtag_pkg: shared definitions for the TAP controller and the debug module.
//   tap_state_e      - fixed 4-bit encoding of the 16 TAP states
//   READ_MEM..BYPASS - instruction opcodes
//   IR_CAPTURE_VALUE - pattern loaded into the IR shifter in CAPTURE_IR
//   tap_next()       - TAP next-state function on {state, tms}
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR        = 4'h0,
    RTI        = 4'h1,
    SHIFT_DR   = 4'h2,
    SEL_DR     = 4'h3,
    CAPTURE_DR = 4'h4,
    UPDATE_DR  = 4'h5,
    EXIT1_DR   = 4'h6,
    PAUSE_DR   = 4'h7,
    EXIT2_DR   = 4'h8,
    SEL_IR     = 4'h9,
    CAPTURE_IR = 4'hA,
    SHIFT_IR   = 4'hB,
    EXIT1_IR   = 4'hC,
    PAUSE_IR   = 4'hD,
    EXIT2_IR   = 4'hE,
    UPDATE_IR  = 4'hF
  } tap_state_e;

  localparam logic [3:0] READ_MEM         = 4'h1;
  localparam logic [3:0] WRITE_MEM        = 4'h2;
  localparam logic [3:0] SET_ADDR         = 4'h3;
  localparam logic [3:0] BYPASS           = 4'hF;
  localparam logic [3:0] IR_CAPTURE_VALUE = 4'b0001;

  // Only transitions that leave the current state are listed; every other
  // {state, tms} combination holds (e.g. TLR with tms=1, SHIFT with tms=0).
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = s;
    case ({s, tms})
      {TLR,        1'b0}: n = RTI;
      {RTI,        1'b1}: n = SEL_DR;
      {SEL_DR,     1'b0}: n = CAPTURE_DR;
      {SEL_DR,     1'b1}: n = SEL_IR;
      {SEL_IR,     1'b0}: n = CAPTURE_IR;
      {SEL_IR,     1'b1}: n = TLR;
      {CAPTURE_DR, 1'b0}: n = SHIFT_DR;
      {CAPTURE_DR, 1'b1}: n = EXIT1_DR;
      {CAPTURE_IR, 1'b0}: n = SHIFT_IR;
      {CAPTURE_IR, 1'b1}: n = EXIT1_IR;
      {SHIFT_DR,   1'b1}: n = EXIT1_DR;
      {SHIFT_IR,   1'b1}: n = EXIT1_IR;
      {EXIT1_DR,   1'b0}: n = PAUSE_DR;
      {EXIT1_DR,   1'b1}: n = UPDATE_DR;
      {EXIT1_IR,   1'b0}: n = PAUSE_IR;
      {EXIT1_IR,   1'b1}: n = UPDATE_IR;
      {PAUSE_DR,   1'b1}: n = EXIT2_DR;
      {PAUSE_IR,   1'b1}: n = EXIT2_IR;
      {EXIT2_DR,   1'b0}: n = SHIFT_DR;
      {EXIT2_DR,   1'b1}: n = UPDATE_DR;
      {EXIT2_IR,   1'b0}: n = SHIFT_IR;
      {EXIT2_IR,   1'b1}: n = UPDATE_IR;
      {UPDATE_DR,  1'b0}: n = RTI;
      {UPDATE_DR,  1'b1}: n = SEL_DR;
      {UPDATE_IR,  1'b0}: n = RTI;
      {UPDATE_IR,  1'b1}: n = SEL_DR;
      default:            n = s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if: link between the TAP controller and the debug module.
//   jtag_state  - encoded TAP state (jtag_pkg::tap_state_e values)
//   tck_rise    - one-clk strobe per synchronized TCK rise
//   tdi_sync    - TDI as sampled at the last TCK rise
//   instruction - current (updated) instruction
//   tdo_dbg     - debug module serial data for non-BYPASS DR scans
// Modports: master = TAP controller, slave = debug module.
interface jtag_tap_ctrl_if #(
  parameter int IR_WIDTH = 4
);
  logic [3:0]          jtag_state;
  logic                tck_rise;
  logic                tdi_sync;
  logic [IR_WIDTH-1:0] instruction;
  logic                tdo_dbg;

  modport master (
    output jtag_state, tck_rise, tdi_sync, instruction,
    input  tdo_dbg
  );

  modport slave (
    input  jtag_state, tck_rise, tdi_sync, instruction,
    output tdo_dbg
  );
endinterface

// File: rtl/jtag_sync_edge.sv
// jtag_sync_edge: SYNC_STAGES-deep synchronizer for a bundle of asynchronous
// pins, with rise/fall detection on bit 0 (the pin used as a clock).
//   clk, reset - system clock, asynchronous active-high reset
//   d          - raw asynchronous pins
//   q          - synchronized pins (last synchronizer stage)
//   rise, fall - combinational single-cycle edge flags for q[0]
module jtag_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rise,
  output logic             fall
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];
  logic             prev;

  // NOTE: non-blocking assignments make each stage take the previous stage's
  // old value, so the chain really is SYNC_STAGES flops deep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this array is a flop chain, not a RAM, so resetting it is cheap
      // and keeps the edge detector from seeing a spurious edge after reset.
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
      prev <= 1'b0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      prev <= stage[SYNC_STAGES-1][0];
    end
  end

  assign q    = stage[SYNC_STAGES-1];
  assign rise =  q[0] & ~prev;
  assign fall = ~q[0] &  prev;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1-style TAP controller, oversampled in clk.
//   clk, reset     - system clock, asynchronous active-high reset
//   tck, tms, tdi  - asynchronous JTAG pins
//   tdo            - JTAG TDO pin, registered on the synchronized TCK fall
//   dbg            - debug-module link (state, strobe, tdi, instruction, tdo_dbg)
// Owns the instruction register and the BYPASS bit; all other data registers
// live in the debug module, which qualifies its actions with tck_rise.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int                  SYNC_STAGES = 2,
  parameter int                  IR_WIDTH    = 4,
  parameter logic [IR_WIDTH-1:0] IR_BYPASS   = BYPASS,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_CAPTURE_VALUE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tck,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  jtag_tap_ctrl_if.master  dbg
);

  logic [2:0]          pins_q;
  logic                tck_rise_c;
  logic                tck_fall_c;
  logic                tms_s;
  logic                tdi_s;
  tap_state_e          state_q;
  tap_state_e          state_d;
  logic                tck_rise_q;
  logic                tdi_sync_q;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] instruction;
  logic                byp;
  logic                is_bypass;

  // All three pins share one synchronizer so tms/tdi are aligned with the
  // detected TCK edge; bit 0 carries tck.
  jtag_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (3)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    ({tdi, tms, tck}),
    .q    (pins_q),
    .rise (tck_rise_c),
    .fall (tck_fall_c)
  );

  assign tms_s     = pins_q[1];
  assign tdi_s     = pins_q[2];
  assign is_bypass = (instruction == IR_BYPASS);

  // NOTE: state_d gets a value on every path, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (tck_rise_c) state_d = tap_next(state_q, tms_s);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= TLR;
      tck_rise_q <= 1'b0;
      tdi_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tck_rise_q <= tck_rise_c;
      if (tck_rise_c) tdi_sync_q <= tdi_s;
    end
  end

  // Shift actions on the rise use the state before the transition; update and
  // TDO actions on the fall use the state entered at the preceding rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_shift    <= '0;
      instruction <= IR_BYPASS;
      byp         <= 1'b0;
      tdo         <= 1'b0;
    end else if (tck_rise_c) begin
      case (state_q)
        CAPTURE_IR: ir_shift <= IR_CAPTURE;
        SHIFT_IR:   ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
        CAPTURE_DR: if (is_bypass) byp <= 1'b0;
        SHIFT_DR:   if (is_bypass) byp <= tdi_s;
        default: ;
      endcase
    end else if (tck_fall_c) begin
      case (state_q)
        UPDATE_IR: instruction <= ir_shift;
        TLR:       instruction <= IR_BYPASS;
        SHIFT_IR:  tdo         <= ir_shift[0];
        SHIFT_DR:  tdo         <= is_bypass ? byp : dbg.tdo_dbg;
        default: ;
      endcase
    end
  end

  assign dbg.jtag_state  = state_q;
  assign dbg.tck_rise    = tck_rise_q;
  assign dbg.tdi_sync    = tdi_sync_q;
  assign dbg.instruction = instruction;

endmodule
